// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: sequences a 32-bit operation through an external
// 1-bit ALU slice, one bit per clock, and assembles result, zero and ovf.
module alu_serial_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        sl_a,
  output logic        sl_b,
  output logic        sl_cin,
  output logic        sl_inv,
  output logic        sl_less,
  output logic [1:0]  sl_signal,
  input  logic        sl_out,
  input  logic        sl_cout,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, b_reg, shift_reg, result_reg;
  logic [2:0]  op_reg;
  logic [4:0]  k_reg;
  logic        carry_reg, zero_reg, ovf_reg;

  logic        accept, last_bit, v;
  logic [31:0] sum_word, fin_result;
  logic        fin_ovf;

  // start is only honoured outside RUN, so a request mid-operation has no effect
  assign accept   = start && (state_reg != RUN);
  assign last_bit = (state_reg == RUN) && (k_reg == 5'd31);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (k_reg == 5'd31) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // At k=31 carry_reg holds the carry into bit 31 and sl_cout the carry out of it
  assign v        = carry_reg ^ sl_cout;
  assign sum_word = {sl_out, shift_reg[30:0]};

  always_comb begin
    fin_result = 32'd0;
    fin_ovf    = 1'b0;
    case (op_reg)
      OP_AND, OP_OR: fin_result = sum_word;
      OP_ADD, OP_SUB: begin
        fin_result = sum_word;
        fin_ovf    = v;
      end
      OP_SLT:  fin_result = {31'd0, sl_out ^ v};
      default: fin_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      op_reg     <= 3'd0;
      k_reg      <= 5'd0;
      carry_reg  <= 1'b0;
      shift_reg  <= 32'd0;
      result_reg <= 32'd0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= a_in;
        b_reg     <= b_in;
        op_reg    <= op;
        k_reg     <= 5'd0;
        carry_reg <= 1'b0;
        shift_reg <= 32'd0;
      end else if (state_reg == RUN) begin
        shift_reg[k_reg] <= sl_out;
        carry_reg        <= sl_cout;
        k_reg            <= last_bit ? 5'd0 : k_reg + 5'd1;
        if (last_bit) begin
          result_reg <= fin_result;
          zero_reg   <= (fin_result == 32'd0);
          ovf_reg    <= fin_ovf;
        end
      end
    end
  end

  always_comb begin
    sl_a      = 1'b0;
    sl_b      = 1'b0;
    sl_cin    = 1'b0;
    sl_inv    = 1'b0;
    sl_less   = 1'b0;
    sl_signal = 2'b00;
    if (state_reg == RUN) begin
      sl_a      = a_reg[k_reg];
      sl_b      = b_reg[k_reg];
      sl_inv    = op_reg[2];
      // SLT runs the slice as a plain subtract and fixes up the sign afterwards
      sl_signal = (op_reg == OP_SLT) ? 2'b10 : op_reg[1:0];
      sl_cin    = (k_reg == 5'd0) ? op_reg[2] : carry_reg;
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign zero   = zero_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a behavioural 1-bit ALU slice
// and a queue of expected {ovf, zero, result} values.
module tb_alu_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a_in, b_in;
  logic        sl_a, sl_b, sl_cin, sl_inv, sl_less;
  logic [1:0]  sl_signal;
  logic        sl_out, sl_cout;
  logic        busy, done, zero, ovf;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  alu_serial_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_inv(sl_inv), .sl_less(sl_less),
    .sl_signal(sl_signal), .sl_out(sl_out), .sl_cout(sl_cout),
    .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf)
  );

  // External 1-bit ALU slice
  logic bb, sum_bit;
  assign bb      = sl_b ^ sl_inv;
  assign sum_bit = sl_a ^ bb ^ sl_cin;
  assign sl_cout = (sl_a & bb) | (sl_a & sl_cin) | (bb & sl_cin);
  always_comb begin
    case (sl_signal)
      2'b00:   sl_out = sl_a & bb;
      2'b01:   sl_out = sl_a | bb;
      2'b10:   sl_out = sum_bit;
      default: sl_out = sl_less;
    endcase
  end

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] o);
    logic [31:0] r;
    logic        v;
    r = 32'd0;
    v = 1'b0;
    case (o)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b111: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = 32'd0;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  // Drive one operation, push its expectation, wait (bounded) for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                        output int lat, output int busy_cyc);
    exp_q.push_back(model(a, b, o));
    @(negedge clk);
    a_in = a; b_in = b; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    $display("op=%b a=%h b=%h -> result=%h zero=%b ovf=%b lat=%0d",
             o, a, b, result, zero, ovf, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 3'b010; a_in = 32'd1; b_in = 32'd2;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, result, zero, ovf} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h zero=%b ovf=%b, required all 0",
               busy, done, result, zero, ovf);
    end
    n_checks++;
    if ({sl_a, sl_b, sl_cin, sl_inv, sl_less, sl_signal} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_slice: sl=%b, required 0",
               {sl_a, sl_b, sl_cin, sl_inv, sl_less, sl_signal});
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] o);
    int lat, bc;
    logic [33:0] e;
    run_op(a, b, o, lat, bc);
    e = exp_q.pop_front();
    n_checks++;
    if ({ovf, zero, result} !== e) begin
      n_fail++;
      $display("FAIL %s: ovf=%b zero=%b result=%h, required ovf=%b zero=%b result=%h",
               name, ovf, zero, result, e[33], e[32], e[31:0]);
    end
    n_checks++;
    if (lat != 32 || bc != 32) begin
      n_fail++;
      $display("FAIL %s_latency: lat=%0d busy_cycles=%0d, required 32/32", name, lat, bc);
    end
    n_checks++;
    if ({sl_a, sl_b, sl_cin, sl_inv, sl_less, sl_signal} !== 7'd0) begin
      n_fail++;
      $display("FAIL %s_slice_idle: sl=%b, required 0", name,
               {sl_a, sl_b, sl_cin, sl_inv, sl_less, sl_signal});
    end
  endtask

  task automatic test_random;
    logic [2:0] codes [5];
    codes = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    for (int i = 0; i < 6; i++)
      test_vector("random", $urandom, $urandom, codes[$urandom_range(0, 4)]);
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bad_busy;
    logic [33:0] e;
    exp_q.push_back(model(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000));
    exp_q.push_back(model(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001));
    @(negedge clk);
    a_in = 32'hF0F0F0F0; b_in = 32'h0FF00FF0; op = 3'b000; start = 1'b1;
    @(negedge clk);
    cyc = 0;
    bad_busy = 0;
    while (!done && cyc < 200) begin
      if (!busy) bad_busy++;
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (result !== e[31:0] || cyc != 32 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: result=%h lat=%0d busy=%b, required %h/32/0",
               result, cyc, busy, e[31:0]);
    end
    $display("b2b AND -> result=%h lat=%0d", result, cyc);
    op = 3'b001;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || result !== e[31:0]) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b result=%h, required busy=1 result=%h",
               busy, result, e[31:0]);
    end
    cyc = 0;
    while (!done && cyc < 200) begin
      if (!busy) bad_busy++;
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (result !== e[31:0] || cyc != 32 || bad_busy != 0) begin
      n_fail++;
      $display("FAIL b2b_second: result=%h lat=%0d busy_gaps=%0d, required %h/32/0",
               result, cyc, bad_busy, e[31:0]);
    end
    $display("b2b OR -> result=%h lat=%0d", result, cyc);
  endtask

  task automatic test_start_ignored;
    int cyc;
    logic [33:0] e;
    exp_q.push_back(model(32'h12345678, 32'h0F0F0F0F, 3'b010));
    @(negedge clk);
    a_in = 32'h12345678; b_in = 32'h0F0F0F0F; op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a_in = 32'hFFFFFFFF; b_in = 32'h0; op = 3'b001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 6;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({ovf, zero, result} !== e || cyc != 32) begin
      n_fail++;
      $display("FAIL start_ignored: result=%h lat=%0d, required %h/32", result, cyc, e[31:0]);
    end
    $display("start at k=5 ignored -> result=%h lat=%0d", result, cyc);
  endtask

  task automatic test_reset_mid_run;
    int saw_done;
    @(negedge clk);
    a_in = 32'hAAAA5555; b_in = 32'h11111111; op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b result=%h zero=%b, required 0/0/0/0",
               busy, done, result, zero);
    end
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    n_checks++;
    if (saw_done != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity cycles=%0d, required 0", saw_done);
    end
    $display("reset at k=10 -> busy=%b result=%h", busy, result);
    test_vector("add_after_reset", 32'd3, 32'd4, 3'b010);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a_in = 32'd0; b_in = 32'd0;
    test_reset();
    test_vector("add_ovf",   32'h7FFFFFFF, 32'h00000001, 3'b010);
    test_vector("sub_zero",  32'd5,        32'd5,        3'b110);
    test_vector("sub_ovf",   32'h80000000, 32'h00000001, 3'b110);
    test_vector("slt_neg",   32'hFFFFFFFF, 32'h00000001, 3'b111);
    test_vector("slt_ovf",   32'h7FFFFFFF, 32'h80000000, 3'b111);
    test_vector("unsup_100", 32'hFFFFFFFF, 32'h00000000, 3'b100);
    test_vector("unsup_011", 32'hDEADBEEF, 32'h12345678, 3'b011);
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
